// File: rtl/mod_delay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_delay_pkg
//  Description : Shared types and helpers for the modulated delay line.
//                Holds the mode and state encodings and the saturating
//                adder used by the mix datapath.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_delay_pkg;

    localparam int c_lfo_step_w = 8;
    localparam int c_fb_shift_w = 3;

    typedef enum logic [1:0] {
        MODE_FIR = 2'd0,
        MODE_IIR = 2'd1
    } mode_t;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_READ  = 2'd2,
        S_MIX   = 2'd3
    } state_t;

    // Adds two sign-extended operands and clamps the result to the signed
    // range of a w-bit word. Operands must already fit in w bits, so the
    // 64-bit intermediate can never overflow.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_ram.sv
`default_nettype none
// ============================================================================
//  Module      : delay_ram
//  Description : Simple dual-port sample memory for the delay line. One
//                write port, one registered read port, no reset, written
//                in a block-RAM friendly form. A read and a write to the
//                same address in one cycle returns the old contents.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_raddr  - read address
//                o_rdata  - read data, one cycle after i_raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_ram #(
    parameter int W     = 24,
    parameter int DEPTH = 20000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mod_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : mod_delay_line
//  Description : Modulated delay effect (FIR/IIR echo, chorus, flanger).
//                One sample per handshake, three cycles accept-to-output.
//                A triangle LFO offsets the delay length; the wet path is
//                attenuated by an arithmetic shift and mixed with
//                saturation. A clear sweep zeroes the memory after reset
//                or on request.
//  Ports       : clk_48    - audio clock
//                rst_n     - synchronous active-low reset
//                in_valid  / in_ready - input handshake
//                x         - input sample (signed)
//                out_valid - one-cycle pulse when y updates
//                y         - output sample (signed, registered)
//                en, mode, delay_len, fb_shift, lfo_depth, lfo_step
//                          - configuration, sampled at the accept edge
//                clear     - request a full memory clear
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_delay_line
    import mod_delay_pkg::*;
#(
    parameter int W     = 24,
    parameter int DEPTH = 20000,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk_48,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     x,
    output logic                    out_valid,
    output logic signed [W-1:0]     y,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [AW-1:0]           delay_len,
    input  logic [c_fb_shift_w-1:0] fb_shift,
    input  logic [AW-1:0]           lfo_depth,
    input  logic [c_lfo_step_w-1:0] lfo_step,
    input  logic                    clear
);

    // LFO arithmetic needs one bit of headroom above the wider operand.
    localparam int            c_lw        = ((AW > c_lfo_step_w) ? AW : c_lfo_step_w) + 1;
    localparam logic [AW-1:0] c_last      = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_depth     = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   c_max_delay = (AW + 1)'(DEPTH - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [AW-1:0]             r_clr_addr;
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_lfo_val;
    logic                      r_lfo_down;
    logic signed [W-1:0]       r_y;
    logic                      r_out_valid;

    logic signed [W-1:0]       r_x;
    logic                      r_en;
    logic [1:0]                r_mode;
    logic [AW-1:0]             r_delay_len;
    logic [c_fb_shift_w-1:0]   r_fb_shift;
    logic [AW-1:0]             r_lfo_depth;
    logic [c_lfo_step_w-1:0]   r_lfo_step;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_ram_we;
    logic [AW-1:0]             w_ram_waddr;
    logic [W-1:0]              w_ram_wdata;
    logic [AW-1:0]             w_rd_addr;
    logic signed [W-1:0]       w_rd_data;
    logic signed [W-1:0]       w_wet;
    logic signed [W-1:0]       w_sum;
    logic signed [W-1:0]       w_wb_data;
    logic [AW-1:0]             w_base;
    logic [AW:0]               w_delay_sum;
    logic [AW:0]               w_delay_eff;
    logic [AW:0]               w_rd_wide;
    logic [c_lw-1:0]           w_lfo_val_x;
    logic [c_lw-1:0]           w_lfo_step_x;
    logic [c_lw-1:0]           w_lfo_depth_x;
    logic [c_lw-1:0]           w_lfo_up;
    logic [AW-1:0]             w_lfo_next;
    logic                      w_lfo_down_next;

    assign w_accept = w_in_ready & in_valid;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_addr == c_last) w_next_state = S_IDLE;
            S_IDLE: begin
                if (clear) begin
                    w_next_state = S_CLEAR;
                end else if (in_valid) begin
                    w_next_state = S_READ;
                end
            end
            S_READ:  w_next_state = S_MIX;
            S_MIX:   w_next_state = S_IDLE;
            default: w_next_state = S_CLEAR;
        endcase
    end

    // The single write port is shared by the clear sweep and the mix write.
    always_comb begin
        w_in_ready  = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_waddr = r_wr_ptr;
        w_ram_wdata = w_wb_data;
        case (r_state)
            S_CLEAR: begin
                w_ram_we    = rst_n;
                w_ram_waddr = r_clr_addr;
                w_ram_wdata = '0;
            end
            S_IDLE:  w_in_ready = !clear;
            S_MIX:   w_ram_we   = rst_n;
            default: ;
        endcase
    end

    // ------------------------------------------------------ read address
    // delay_len of 0 is promoted to 1 so the read never hits the slot
    // about to be written.
    always_comb begin
        w_base      = (r_delay_len == '0) ? AW'(1) : r_delay_len;
        w_delay_sum = {1'b0, w_base} + {1'b0, r_lfo_val};
        w_delay_eff = (w_delay_sum > c_max_delay) ? c_max_delay : w_delay_sum;
        if ({1'b0, r_wr_ptr} >= w_delay_eff) begin
            w_rd_wide = {1'b0, r_wr_ptr} - w_delay_eff;
        end else begin
            w_rd_wide = {1'b0, r_wr_ptr} + c_depth - w_delay_eff;
        end
        w_rd_addr = AW'(w_rd_wide);
    end

    // --------------------------------------------------------------- mix
    assign w_wet     = w_rd_data >>> r_fb_shift;
    assign w_sum     = W'(sat_add(64'(r_x), 64'(w_wet), W));
    assign w_wb_data = ((r_mode == MODE_IIR) && r_en) ? w_sum : r_x;

    // --------------------------------------------------------------- LFO
    always_comb begin
        w_lfo_val_x     = c_lw'(r_lfo_val);
        w_lfo_step_x    = c_lw'(r_lfo_step);
        w_lfo_depth_x   = c_lw'(r_lfo_depth);
        w_lfo_up        = w_lfo_val_x + w_lfo_step_x;
        w_lfo_next      = r_lfo_val;
        w_lfo_down_next = r_lfo_down;
        if (r_lfo_depth == '0) begin
            w_lfo_next      = '0;
            w_lfo_down_next = 1'b0;
        end else if (r_lfo_val > r_lfo_depth) begin
            // Depth was reduced under the current excursion: snap to the
            // new peak and head back down.
            w_lfo_next      = r_lfo_depth;
            w_lfo_down_next = 1'b1;
        end else if (!r_lfo_down) begin
            if (w_lfo_up >= w_lfo_depth_x) begin
                w_lfo_next      = r_lfo_depth;
                w_lfo_down_next = 1'b1;
            end else begin
                w_lfo_next = AW'(w_lfo_up);
            end
        end else begin
            if (w_lfo_val_x <= w_lfo_step_x) begin
                w_lfo_next      = '0;
                w_lfo_down_next = 1'b0;
            end else begin
                w_lfo_next = AW'(w_lfo_val_x - w_lfo_step_x);
            end
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            r_clr_addr  <= '0;
            r_wr_ptr    <= '0;
            r_lfo_val   <= '0;
            r_lfo_down  <= 1'b0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            // Parked at zero outside the sweep so a later clear starts at 0.
            r_clr_addr  <= (r_state == S_CLEAR && r_clr_addr != c_last) ?
                           r_clr_addr + AW'(1) : '0;
            if (r_state == S_MIX) begin
                r_y         <= r_en ? w_sum : r_x;
                r_out_valid <= 1'b1;
                r_wr_ptr    <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + AW'(1);
                r_lfo_val   <= w_lfo_next;
                r_lfo_down  <= w_lfo_down_next;
            end
        end
    end

    // Configuration is captured only at the accept edge.
    always_ff @(posedge clk_48) begin
        if (rst_n && w_accept) begin
            r_x         <= x;
            r_en        <= en;
            r_mode      <= mode;
            r_delay_len <= delay_len;
            r_fb_shift  <= fb_shift;
            r_lfo_depth <= lfo_depth;
            r_lfo_step  <= lfo_step;
        end
    end

    delay_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_delay_ram (
        .clk     (clk_48),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;

endmodule
`default_nettype wire
